sample_window_reg: RTL and testbench

Parametrised sample-window register: a WIDTH-bit by DEPTH-entry shift register with synchronous load and clear, a fill counter, a full flag, a selectable tap, and a running window sum. It generalises the team's fixed 8-bit load/clear register. It sits between the ADC sample path and the tuner's averaging and period-detection logic, providing the last DEPTH samples and their sum each cycle.

---
 rtl/sample_window_if.sv | 49 ++++
 rtl/sample_window_reg.sv | 93 +++++++++
 tb/tb_sample_window_reg.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sample_window_if.sv
// ---------------------------------------------------------------------------
// sample_window_if
//
// Bundles the control, sample and observation signals of sample_window_reg.
// WIDTH and DEPTH must match the parameters of the attached register.
//
//   master : drives load, clear, d, tap_sel; observes the window outputs
//   slave  : the window register itself
//
//   load      1      shift d into the newest stage on the next edge
//   clear     1      zero the whole window on the next edge (beats load)
//   d         WIDTH  unsigned sample in
//   tap_sel   TW     stage index for q_tap (0 = newest)
//   q_newest  WIDTH  newest stage
//   q_oldest  WIDTH  oldest stage
//   q_tap     WIDTH  selected stage, 0 when tap_sel >= DEPTH
//   count     CW     number of valid entries, 0..DEPTH
//   full      1      count == DEPTH
//   sum       SW     unsigned sum of all stages
// ---------------------------------------------------------------------------
interface sample_window_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(DEPTH);
  localparam int SW = WIDTH + $clog2(DEPTH);

  logic             load;
  logic             clear;
  logic [WIDTH-1:0] d;
  logic [TW-1:0]    tap_sel;
  logic [WIDTH-1:0] q_newest;
  logic [WIDTH-1:0] q_oldest;
  logic [WIDTH-1:0] q_tap;
  logic [CW-1:0]    count;
  logic             full;
  logic [SW-1:0]    sum;

  modport master (
    output load, clear, d, tap_sel,
    input  q_newest, q_oldest, q_tap, count, full, sum
  );

  modport slave (
    input  load, clear, d, tap_sel,
    output q_newest, q_oldest, q_tap, count, full, sum
  );
endinterface

// File: rtl/sample_window_reg.sv
// ---------------------------------------------------------------------------
// sample_window_reg
//
// WIDTH-bit by DEPTH-entry sample window: a shift register with synchronous
// load and clear, a saturating fill counter, a full flag, a selectable tap
// and a running window sum. Feeds the tuner's averaging and period-detection
// logic with the last DEPTH samples and their sum every cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (deassertion synchronised upstream)
//   bus    sample_window_if.slave (load/clear/d/tap_sel in; window out)
// ---------------------------------------------------------------------------
module sample_window_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic             clk,
  input logic             reset,
  sample_window_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(DEPTH);
  localparam int SW = WIDTH + $clog2(DEPTH);

  logic [WIDTH-1:0] stage_p0 [DEPTH];
  logic [CW-1:0]    count_p0;
  logic [SW-1:0]    sum_p0;

  // Fill counter saturates at DEPTH so full never drops while loading.
  function automatic logic [CW-1:0] count_sat_inc(input logic [CW-1:0] c);
    if (c == CW'(DEPTH)) begin
      return c;
    end
    return c + CW'(1);
  endfunction

  // Sliding sum: add the incoming sample, drop the outgoing one. Unfilled
  // stages are zero, so the same rule is exact before and after full. The
  // add is done one bit wider so the intermediate never wraps.
  function automatic logic [SW-1:0] window_sum(
    input logic [SW-1:0]    s,
    input logic [WIDTH-1:0] din,
    input logic [WIDTH-1:0] drop
  );
    logic [SW:0] acc;
    acc = {1'b0, s} + (SW+1)'(din);
    acc = acc - (SW+1)'(drop);
    return acc[SW-1:0];
  endfunction

  // ---- stage p0: window registers --------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_p0[i] <= '0;
      end
      count_p0 <= '0;
      sum_p0   <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_p0[i] <= '0;
      end
      count_p0 <= '0;
      sum_p0   <= '0;
    end else if (bus.load) begin
      stage_p0[0] <= bus.d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_p0[i] <= stage_p0[i-1];
      end
      count_p0 <= count_sat_inc(count_p0);
      sum_p0   <= window_sum(sum_p0, bus.d, stage_p0[DEPTH-1]);
    end
  end

  // ---- outputs: direct register taps plus combinational tap mux --------
  always_comb begin
    bus.q_tap = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.tap_sel == TW'(i)) begin
        bus.q_tap = stage_p0[i];
      end
    end
  end

  assign bus.q_newest = stage_p0[0];
  assign bus.q_oldest = stage_p0[DEPTH-1];
  assign bus.count    = count_p0;
  assign bus.full     = (count_p0 == CW'(DEPTH));
  assign bus.sum      = sum_p0;

endmodule

// File: tb/tb_sample_window_reg.sv
module tb_sample_window_reg;

  logic clk = 1'b0;
  logic reset;

  always #50 clk = ~clk;

  sample_window_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
  sample_window_if #(.WIDTH(8), .DEPTH(5)) bus5 ();

  sample_window_reg #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  sample_window_reg #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference window: loaded samples since the last clear/reset, newest
  // first, trimmed to the largest depth under test.
  int win[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int m_stage(input int i);
    return (i < win.size()) ? win[i] : 0;
  endfunction

  function automatic int m_count(input int dep);
    return (win.size() < dep) ? win.size() : dep;
  endfunction

  function automatic int m_sum(input int dep);
    int s = 0;
    for (int i = 0; i < dep; i++) s += m_stage(i);
    return s;
  endfunction

  task automatic drive(input logic ld, input logic clr, input logic [7:0] dv);
    bus4.load = ld; bus4.clear = clr; bus4.d = dv;
    bus5.load = ld; bus5.clear = clr; bus5.d = dv;
  endtask

  task automatic step(input logic ld, input logic clr, input logic [7:0] dv);
    @(negedge clk);
    drive(ld, clr, dv);
    bus4.tap_sel = 2'($urandom_range(0, 3));
    bus5.tap_sel = 3'($urandom_range(0, 7));
    @(posedge clk);
    if (clr) win.delete();
    else if (ld) begin
      win.push_front(int'(dv));
      if (win.size() > 5) void'(win.pop_back());
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    int s5;
    check({tag, ".newest4"}, 32'(bus4.q_newest), 32'(m_stage(0)));
    check({tag, ".oldest4"}, 32'(bus4.q_oldest), 32'(m_stage(3)));
    check({tag, ".count4"},  32'(bus4.count),    32'(m_count(4)));
    check({tag, ".full4"},   32'(bus4.full),     32'(m_count(4) == 4));
    check({tag, ".sum4"},    32'(bus4.sum),      32'(m_sum(4)));
    check({tag, ".tap4"},    32'(bus4.q_tap),    32'(m_stage(int'(bus4.tap_sel))));
    check({tag, ".newest5"}, 32'(bus5.q_newest), 32'(m_stage(0)));
    check({tag, ".oldest5"}, 32'(bus5.q_oldest), 32'(m_stage(4)));
    check({tag, ".count5"},  32'(bus5.count),    32'(m_count(5)));
    check({tag, ".full5"},   32'(bus5.full),     32'(m_count(5) == 5));
    check({tag, ".sum5"},    32'(bus5.sum),      32'(m_sum(5)));
    s5 = int'(bus5.tap_sel);
    check({tag, ".tap5"},    32'(bus5.q_tap),    32'((s5 < 5) ? m_stage(s5) : 0));
  endtask

  // Walks every tap index on both windows within one cycle.
  task automatic tap_sweep(input string tag);
    for (int s = 0; s < 8; s++) begin
      if (s < 4) bus4.tap_sel = 2'(s);
      bus5.tap_sel = 3'(s);
      #1;
      if (s < 4) check({tag, ".sweep4"}, 32'(bus4.q_tap), 32'(m_stage(s)));
      check({tag, ".sweep5"}, 32'(bus5.q_tap), 32'((s < 5) ? m_stage(s) : 0));
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    bus4.tap_sel = '0;
    bus5.tap_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // Partial fill
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    check_all("fill3");
    bus4.tap_sel = 2'd1;
    #1;
    check("fill3.count", 32'(bus4.count), 32'd3);
    check("fill3.full", 32'(bus4.full), 32'd0);
    check("fill3.newest", 32'(bus4.q_newest), 32'h33);
    check("fill3.oldest", 32'(bus4.q_oldest), 32'h00);
    check("fill3.tap1", 32'(bus4.q_tap), 32'h22);
    check("fill3.sum", 32'(bus4.sum), 32'h066);

    // Fill and overflow
    step(1'b1, 1'b0, 8'h44);
    check_all("fill4");
    check("fill4.full", 32'(bus4.full), 32'd1);
    check("fill4.count", 32'(bus4.count), 32'd4);
    check("fill4.oldest", 32'(bus4.q_oldest), 32'h11);
    check("fill4.sum", 32'(bus4.sum), 32'h0AA);
    step(1'b1, 1'b0, 8'h55);
    check_all("ovf");
    check("ovf.oldest", 32'(bus4.q_oldest), 32'h22);
    check("ovf.sum", 32'(bus4.sum), 32'h0EE);
    check("ovf.count", 32'(bus4.count), 32'd4);

    // Clear beats load
    step(1'b1, 1'b1, 8'h99);
    check_all("clr");
    tap_sweep("clr");
    check("clr.count", 32'(bus4.count), 32'd0);
    check("clr.sum", 32'(bus4.sum), 32'd0);
    check("clr.full", 32'(bus4.full), 32'd0);
    step(1'b1, 1'b0, 8'h99);
    check_all("clr.next");
    check("clr.next.count", 32'(bus4.count), 32'd1);
    check("clr.next.sum", 32'(bus4.sum), 32'h099);

    // Maximum sum
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'hFF);
    check_all("max");
    tap_sweep("max");
    check("max.sum4", 32'(bus4.sum), 32'h3FC);
    check("max.sum5", 32'(bus5.sum), 32'h4FB);
    check("max.full", 32'(bus4.full), 32'd1);

    // Asynchronous reset between edges, with load held
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h5A);
    #10;
    reset = 1'b0;
    win.delete();
    #1;
    check_all("arst");
    check("arst.sum", 32'(bus4.sum), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_all("arst.hold");
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    reset = 1'b1;

    // Hold with tap sweep
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'($urandom));
      check_all("hold");
      tap_sweep("hold");
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0), 8'($urandom));
      check_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
